mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF-stage fetch requester (inst) and the EXE-stage load/store requester (data).
//  Sits between the pipeline stages and the future AXI bridge; the pipeline sees two independent SRAM-like ports.
//  Grants one request per cycle and holds the grant until the memory accepts it.
//  Tracks in-order outstanding transactions and routes each data_ok/rdata back to its owner.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width; wstrb width is DATA_W/8
//  MAX_OUT  2   max accepted-but-unreturned transactions, >=1
// PORTS
//  clk              in   1        single clock, rising edge
//  resetn           in   1        synchronous reset, active-low
//  inst_req         in   1        fetch request valid
//  inst_addr        in   ADDR_W   fetch address (read-only requester; wr forced 0, size forced 2)
//  inst_addr_ok     out  1        fetch request accepted this cycle
//  inst_data_ok     out  1        fetch read data returned this cycle
//  inst_rdata       out  DATA_W   fetch read data
//  data_req         in   1        load/store request valid
//  data_wr          in   1        1 = store
//  data_size        in   2        0 byte, 1 half, 2 word
//  data_addr        in   ADDR_W   load/store address
//  data_wstrb       in   DATA_W/8 byte strobes, stores only
//  data_wdata       in   DATA_W   store data
//  data_addr_ok     out  1        load/store request accepted this cycle
//  data_data_ok     out  1        load data returned / store acknowledged
//  data_rdata       out  DATA_W   load data
//  mem_req,mem_wr,mem_size,mem_addr,mem_wstrb,mem_wdata  out  1,1,2,ADDR_W,DATA_W/8,DATA_W  granted request
//  mem_addr_ok      in   1        memory accepted mem_req
//  mem_data_ok      in   1        memory returns oldest outstanding transaction
//  mem_rdata        in   DATA_W   returned read data
//  arb_err          out  1        sticky: mem_data_ok with no outstanding transaction
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): grant=NONE, outstanding FIFO empty, count=0, arb_err=0.
//    All handshake outputs drop to 0 on the next cycle.
//    Reset mid-transaction discards all tracking; the memory side must be reset in the same cycle.
//  Grant FSM, registered grant state:
//    IDLE: if count<MAX_OUT, data_req has priority over inst_req; the winner drives mem_* combinationally this cycle.
//          If mem_addr_ok is absent, go to HOLD_D or HOLD_I.
//    HOLD_x: keep driving x's request regardless of the other requester.
//          Go to IDLE on mem_addr_ok.
//          Requesters keep req/fields stable until addr_ok (SRAM-like rule); the arbiter does not re-check this.
//  Acceptance: accept = mem_req & mem_addr_ok.
//    Pulse the owner's *_addr_ok in the same cycle (combinational pass-through).
//    Push the owner id (0 inst, 1 data) into the FIFO.
//  mem_req = (grant valid) & (count<MAX_OUT).
//    count is the registered value; a same-cycle pop does not free a slot (no bypass).
//  Return: on mem_data_ok, pop the FIFO head and pulse the head-owner's *_data_ok with *_rdata=mem_rdata (combinational).
//    The other requester's *_data_ok=0; both *_rdata carry mem_rdata.
//  Simultaneous accept and return: push and pop both occur; count is unchanged.
//  FIFO: depth MAX_OUT, wrapping pointers of width clog2(MAX_OUT), count 0..MAX_OUT.
//  Full (count==MAX_OUT): mem_req=0, grant state held.
//  mem_data_ok when empty: ignored, no pop, arb_err<=1 (stays set until reset).
//  Latency: the arbiter adds 0 cycles on request and 0 cycles on return; arbitration overhead is combinational only.
//  Starvation: data has strict priority. A data_req only recurs after a new EXE instruction, so inst progress is guaranteed.
// STRUCTURE
//  Shared package: SIZE_BYTE/HALF/WORD, SRC_INST=0/SRC_DATA=1, grant-state encodings IDLE/HOLD_I/HOLD_D.
//  Sub-module: arb_id_fifo (1-bit-wide, MAX_OUT-deep sync FIFO: push, pop, head, count, full, empty).
//  The top of the block is the grant FSM plus muxes.
// TESTING
//  1. inst_req=1 only, addr 0x1c000000, mem_addr_ok=1 same cycle, mem_data_ok 2 cycles later with rdata=0x02800c0c
//     -> inst_addr_ok pulse, then inst_data_ok=1 with inst_rdata=0x02800c0c; data_data_ok stays 0.
//  2. inst_req and data_req in the same cycle (data store addr 0x100, wstrb=4'hf, wdata=0x12345678)
//     -> mem_wr=1, mem_addr=0x100 first; the inst request is accepted the next cycle.
//  3. inst granted, mem_addr_ok held 0 for 3 cycles while data_req rises
//     -> mem_addr stays the inst address (HOLD_I) until accepted; the data request follows.
//  4. MAX_OUT=2: two accepts with no data_ok -> mem_req=0 while count==2.
//     One data_ok -> count=1, mem_req reasserts the next cycle; returns route inst then data in order.
//  5. Accept and data_ok in the same cycle at count=1 -> count stays 1; the returned owner is the old head.
//  6. mem_data_ok with empty FIFO -> no *_data_ok, arb_err=1 until resetn=0; resetn=0 mid-HOLD_D -> grant=IDLE, count=0.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: access sizes,
// requester ids and grant-state encodings.
package mem_req_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } gnt_state_t;

endpackage

// File: rtl/mem_req_arbiter_arb_id_fifo.sv
// Owner-id FIFO: remembers, in acceptance order, which requester owns each
// transaction the memory has accepted but not yet returned.
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [(1 << PTR_W)-1:0] ids;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = ids[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap at DEPTH-1 so any depth works.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Id storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ids[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter sharing one SRAM-like memory port between the fetch
// (inst) and load/store (data) requesters. Data has strict priority; a grant
// is held until the memory accepts it, and returns are routed in order.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  gnt_state_t       gnt_state;
  logic             gnt_valid;
  logic             gnt_src;
  logic             has_room;
  logic             accept;
  logic             ret_pop;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Select the current winner: a held grant wins outright, otherwise data beats inst.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_DATA;
    case (gnt_state)
      IDLE: begin
        if (data_req) begin
          gnt_valid = 1'b1;
          gnt_src   = SRC_DATA;
        end else if (inst_req) begin
          gnt_valid = 1'b1;
          gnt_src   = SRC_INST;
        end
      end
      HOLD_I: begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_INST;
      end
      HOLD_D: begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_DATA;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_DATA;
      end
    endcase
  end

  // Registered occupancy only: a return in the same cycle does not open a slot.
  assign has_room = (fifo_count < CNT_W'(MAX_OUT));
  assign mem_req  = gnt_valid & has_room;
  assign accept   = mem_req & mem_addr_ok;

  // Steer the granted requester onto the memory port; fetches are word reads.
  always_comb begin
    if (gnt_src == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = 1'b0;
      mem_size  = SIZE_WORD;
      mem_addr  = inst_addr;
      mem_wstrb = '0;
      mem_wdata = '0;
    end
  end

  assign inst_addr_ok = accept & (gnt_src == SRC_INST);
  assign data_addr_ok = accept & (gnt_src == SRC_DATA);

  // Returns belong to the oldest outstanding transaction; stray returns are dropped.
  assign ret_pop      = mem_data_ok & ~fifo_empty;
  assign inst_data_ok = ret_pop & (fifo_head == SRC_INST);
  assign data_data_ok = ret_pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Grant FSM: park on the winner until accepted; freeze while no slot is free.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gnt_state <= IDLE;
    end else if (!fifo_full) begin
      case (gnt_state)
        IDLE: begin
          if (gnt_valid && !mem_addr_ok) begin
            gnt_state <= (gnt_src == SRC_DATA) ? HOLD_D : HOLD_I;
          end
        end
        HOLD_I, HOLD_D: begin
          if (mem_addr_ok) begin
            gnt_state <= IDLE;
          end
        end
        default: gnt_state <= IDLE;
      endcase
    end
  end

  // Sticky protocol error: memory returned data with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      arb_err <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      arb_err <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (gnt_src),
    .pop    (ret_pop),
    .head   (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: grant priority, hold, full stall,
// in-order return routing, simultaneous accept/return, error flag and reset.
module tb_mem_req_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;

  logic                clk;
  logic                resetn;
  logic                inst_req;
  logic [ADDR_W-1:0]   inst_addr;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [DATA_W-1:0]   inst_rdata;
  logic                data_req;
  logic                data_wr;
  logic [1:0]          data_size;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;
  logic                mem_req;
  logic                mem_wr;
  logic [1:0]          mem_size;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;
  logic                arb_err;

  int vectors;
  int miscompares;

  mem_req_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .arb_err      (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = '0;
    data_wstrb  = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;

    // Reset state
    tick();
    tick();
    resetn = 1'b1;
    settle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_arb_err", arb_err, 0);

    // 1: single fetch, accepted immediately, data two cycles later
    tick();
    inst_req    = 1'b1;
    inst_addr   = 32'h1c000000;
    mem_addr_ok = 1'b1;
    settle();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1c000000);
    chk("t1_mem_wr", mem_wr, 0);
    chk("t1_mem_size", mem_size, 2);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    settle();
    chk("t1_idle_mem_req", mem_req, 0);
    chk("t1_early_data_ok", inst_data_ok, 0);
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h02800c0c;
    settle();
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h02800c0c);
    chk("t1_data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;

    // 2: simultaneous requests, store wins, fetch follows
    inst_req    = 1'b1;
    inst_addr   = 32'h1c000004;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_size   = 2'd2;
    data_addr   = 32'h00000100;
    data_wstrb  = 4'hf;
    data_wdata  = 32'h12345678;
    mem_addr_ok = 1'b1;
    settle();
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_addr", mem_addr, 32'h00000100);
    chk("t2_mem_wstrb", mem_wstrb, 4'hf);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok_lost", inst_addr_ok, 0);
    tick();
    data_req = 1'b0;
    settle();
    chk("t2_next_mem_addr", mem_addr, 32'h1c000004);
    chk("t2_next_mem_wr", mem_wr, 0);
    chk("t2_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'haaaa0000;
    settle();
    chk("t2_ret0_data_ok", data_data_ok, 1);
    chk("t2_ret0_inst_ok", inst_data_ok, 0);
    chk("t2_ret0_rdata", data_rdata, 32'haaaa0000);
    tick();
    mem_rdata = 32'hbbbb0000;
    settle();
    chk("t2_ret1_inst_ok", inst_data_ok, 1);
    chk("t2_ret1_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;

    // 3: fetch held while data request rises
    inst_req  = 1'b1;
    inst_addr = 32'h1c000008;
    data_wr   = 1'b0;
    data_size = 2'd0;
    data_addr = 32'h00000200;
    data_wstrb = 4'h0;
    settle();
    chk("t3_c0_mem_addr", mem_addr, 32'h1c000008);
    chk("t3_c0_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b1;
    settle();
    chk("t3_c1_hold_addr", mem_addr, 32'h1c000008);
    chk("t3_c1_data_addr_ok", data_addr_ok, 0);
    tick();
    settle();
    chk("t3_c2_hold_addr", mem_addr, 32'h1c000008);
    chk("t3_c2_hold_wr", mem_wr, 0);
    tick();
    mem_addr_ok = 1'b1;
    settle();
    chk("t3_acc_mem_addr", mem_addr, 32'h1c000008);
    chk("t3_acc_inst_ok", inst_addr_ok, 1);
    chk("t3_acc_data_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0;
    settle();
    chk("t3_data_mem_addr", mem_addr, 32'h00000200);
    chk("t3_data_mem_size", mem_size, 0);
    chk("t3_data_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 1'b0;

    // 4: two outstanding (inst, data) -> stall; return frees slot next cycle
    inst_req  = 1'b1;
    inst_addr = 32'h1c00000c;
    settle();
    chk("t4_full_mem_req", mem_req, 0);
    chk("t4_full_inst_addr_ok", inst_addr_ok, 0);
    tick();
    settle();
    chk("t4_full_mem_req2", mem_req, 0);
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h11111111;
    settle();
    chk("t4_pop_no_bypass", mem_req, 0);
    chk("t4_ret_inst_ok", inst_data_ok, 1);
    chk("t4_ret_data_ok", data_data_ok, 0);
    tick();

    // 5: accept and return together at count=1; head is the data entry
    mem_rdata = 32'h22222222;
    settle();
    chk("t5_mem_req", mem_req, 1);
    chk("t5_mem_addr", mem_addr, 32'h1c00000c);
    chk("t5_inst_addr_ok", inst_addr_ok, 1);
    chk("t5_data_data_ok", data_data_ok, 1);
    chk("t5_inst_data_ok", inst_data_ok, 0);
    chk("t5_rdata", data_rdata, 32'h22222222);
    tick();
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_rdata   = 32'h33333333;
    settle();
    chk("t5_left_inst_ok", inst_data_ok, 1);
    chk("t5_left_data_ok", data_data_ok, 0);
    chk("t5_no_err_yet", arb_err, 0);

    // 6: stray return sets sticky error
    tick();
    settle();
    chk("t6_stray_inst_ok", inst_data_ok, 0);
    chk("t6_stray_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    settle();
    chk("t6_arb_err_set", arb_err, 1);
    tick();
    tick();
    settle();
    chk("t6_arb_err_sticky", arb_err, 1);

    // 6: reset with one outstanding fetch and a data grant parked in HOLD_D
    inst_req    = 1'b1;
    inst_addr   = 32'h1c000010;
    mem_addr_ok = 1'b1;
    tick();
    inst_req    = 1'b0;
    data_req    = 1'b1;
    data_addr   = 32'h00000300;
    mem_addr_ok = 1'b0;
    tick();
    data_req = 1'b0;
    inst_req = 1'b1;
    inst_addr = 32'h1c000014;
    settle();
    chk("t6_hold_d_addr", mem_addr, 32'h00000300);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    settle();
    chk("t6_rst_arb_err", arb_err, 0);
    chk("t6_rst_idle_addr", mem_addr, 32'h1c000014);
    chk("t6_rst_idle_wr", mem_wr, 0);
    mem_addr_ok = 1'b1;
    settle();
    chk("t6_rst_acc0", inst_addr_ok, 1);
    tick();
    settle();
    chk("t6_rst_acc1", inst_addr_ok, 1);
    tick();
    settle();
    chk("t6_rst_full", mem_req, 0);
    inst_req    = 1'b0;
    mem_addr_ok = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
